hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv_pkg.sv | 34 +++
 rtl/hilo_muldiv_div_core.sv | 85 ++++++++
 rtl/hilo_muldiv.sv | 154 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// state encoding, divide-by-zero constant and the 64-bit product helper.
package hilo_muldiv_pkg;

    localparam logic [7:0]  OP_MULT  = 8'h14;
    localparam logic [7:0]  OP_MULTU = 8'h15;
    localparam logic [7:0]  OP_DIV   = 8'h16;
    localparam logic [7:0]  OP_DIVU  = 8'h17;

    // LO value returned when the divisor is zero
    localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

    // Counter value of the final (32nd) divide iteration
    localparam logic [4:0]  DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // 32x32 -> 64 product; sign-extending both operands to 64 bits makes
    // the low 64 bits of the product correct for signed and unsigned alike.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// div_core: iterative restoring radix-2 divider, one quotient bit per
// cycle over 32 cycles. Works on operand magnitudes and applies the sign
// rules to the final iteration's result (quotient negated when the operand
// signs differ, remainder follows the dividend).
module div_core
    import hilo_muldiv_pkg::*;
(
    input  logic        cpu_clk_50M,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [63:0] result_o,
    output logic        done_o
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        negq_q;
    logic        negr_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        qbit;
    logic        last;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    assign a_mag = (signed_i && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
    assign b_mag = (signed_i && divisor_i[31])  ? (~divisor_i + 32'd1)  : divisor_i;

    // Quotient register doubles as the dividend shift register: its MSB is
    // shifted into the partial remainder while the new quotient bit enters
    // at the LSB. Partial remainder < divisor, so 33 bits never overflow.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign qbit    = ~diff[32];
    assign rem_d   = qbit ? diff[31:0] : shifted[31:0];
    assign quo_d   = {quo_q[30:0], qbit};

    assign last     = busy_q && (cnt_q == DIV_LAST);
    assign busy_o   = busy_q;
    assign done_o   = last;
    assign result_o = {negr_q ? (~rem_d + 32'd1) : rem_d,
                       negq_q ? (~quo_d + 32'd1) : quo_d};

    // Load magnitudes on start, then iterate until the 32nd bit is produced
    always_ff @(posedge cpu_clk_50M or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dsr_q  <= 32'd0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (flush_i) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= 5'd0;
            rem_q  <= 32'd0;
            quo_q  <= a_mag;
            dsr_q  <= b_mag;
            negq_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
            negr_q <= signed_i && dividend_i[31];
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (last)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage multiply/divide unit with the architectural
// HI/LO register. MULT/MULTU complete one cycle after start; DIV/DIVU use
// the iterative div_core. Divide support is built only when HILO_DIV_EN is
// defined; otherwise DIV/DIVU finish in one cycle with a zero result.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic        cpu_clk_50M,
    input  logic        rst,
    input  logic        md_start_i,
    input  logic [7:0]  md_aluop_i,
    input  logic [31:0] md_src1_i,
    input  logic [31:0] md_src2_i,
    input  logic        md_flush_i,
    input  logic        wb_whilo_i,
    input  logic [63:0] wb_hilo_i,
    output logic        md_stall_o,
    output logic        md_done_o,
    output logic [63:0] md_hilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_state_e   state_q;
    logic        done_q;
    logic        mul_sel_q;
    logic        mul_sgn_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [63:0] res_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        op_mul;
    logic        op_div;
    logic        sample;
    logic [63:0] mul_res;
    logic        div_done;
    logic        div_busy;
    logic [63:0] div_res;

    assign op_mul = (md_aluop_i == OP_MULT) || (md_aluop_i == OP_MULTU);
    assign op_div = (md_aluop_i == OP_DIV)  || (md_aluop_i == OP_DIVU);
    assign sample = (state_q == ST_IDLE) && md_start_i && (op_mul || op_div) && !md_flush_i;

    // While reset is held the FSM sits in IDLE, so the start term is masked
    // to keep the pipeline from stalling on a reset-time request.
    assign md_stall_o = !rst && (sample || (state_q == ST_RUN));

`ifdef HILO_DIV_EN
    logic div_go;
    assign div_go = sample && op_div && (md_src2_i != 32'd0);

    div_core u_div (
        .cpu_clk_50M (cpu_clk_50M),
        .rst         (rst),
        .start_i     (div_go),
        .signed_i    (md_aluop_i == OP_DIV),
        .dividend_i  (md_src1_i),
        .divisor_i   (md_src2_i),
        .flush_i     (md_flush_i),
        .busy_o      (div_busy),
        .result_o    (div_res),
        .done_o      (div_done)
    );
`else
    assign div_done = 1'b0;
    assign div_busy = 1'b0;
    assign div_res  = 64'd0;
`endif

    // Operands are captured at start; the product is formed from the
    // registered operands during DONE so the multiplier gets a full cycle.
    assign mul_res   = mul64(opa_q, opb_q, mul_sgn_q);
    assign md_hilo_o = ((state_q == ST_DONE) && mul_sel_q) ? mul_res : res_q;
    assign md_done_o = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    // Control FSM: IDLE samples ops, RUN waits on the divider, DONE pulses
    always_ff @(posedge cpu_clk_50M or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            mul_sel_q <= 1'b0;
            mul_sgn_q <= 1'b0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            res_q     <= 64'd0;
        end else begin
            done_q <= 1'b0;
            // Keep the product visible after DONE, even if DONE is flushed
            if ((state_q == ST_DONE) && mul_sel_q)
                res_q <= mul_res;
            if (md_flush_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sample) begin
                            opa_q     <= md_src1_i;
                            opb_q     <= md_src2_i;
                            mul_sgn_q <= (md_aluop_i == OP_MULT);
                            mul_sel_q <= op_mul;
                            if (op_mul) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
`ifdef HILO_DIV_EN
                            else if (md_src2_i == 32'd0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                res_q   <= {md_src1_i, DIV0_LO};
                            end else begin
                                state_q <= ST_RUN;
                            end
`else
                            else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                res_q   <= 64'd0;
                            end
`endif
                        end
                    end
                    ST_RUN: begin
                        if (div_done) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            res_q   <= div_res;
                        end else if (!div_busy) begin
                            // Divider lost its operation: recover instead of hanging
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Architectural HI/LO, written only from write-back
    always_ff @(posedge cpu_clk_50M or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (wb_whilo_i) begin
            hi_q <= wb_hilo_i[63:32];
            lo_q <= wb_hilo_i[31:0];
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected results and completion cycles
// are queued at issue time from an arithmetic reference model; a negedge
// monitor pops and compares on every md_done_o pulse.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic        cpu_clk_50M = 1'b0;
    logic        rst         = 1'b1;
    logic        md_start_i  = 1'b0;
    logic [7:0]  md_aluop_i  = 8'h00;
    logic [31:0] md_src1_i   = 32'd0;
    logic [31:0] md_src2_i   = 32'd0;
    logic        md_flush_i  = 1'b0;
    logic        wb_whilo_i  = 1'b0;
    logic [63:0] wb_hilo_i   = 64'd0;
    logic        md_stall_o;
    logic        md_done_o;
    logic [63:0] md_hilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    hilo_muldiv dut (
        .cpu_clk_50M (cpu_clk_50M),
        .rst         (rst),
        .md_start_i  (md_start_i),
        .md_aluop_i  (md_aluop_i),
        .md_src1_i   (md_src1_i),
        .md_src2_i   (md_src2_i),
        .md_flush_i  (md_flush_i),
        .wb_whilo_i  (wb_whilo_i),
        .wb_hilo_i   (wb_hilo_i),
        .md_stall_o  (md_stall_o),
        .md_done_o   (md_done_o),
        .md_hilo_o   (md_hilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    typedef struct {
        logic [63:0] hilo;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge cpu_clk_50M) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the op semantics
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      q;
        longint      rm;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = 64'd0;
        case (op)
            8'h14: r = 64'(sa * sbv);
            8'h15: r = {32'd0, a} * {32'd0, b};
`ifdef HILO_DIV_EN
            8'h16: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sbv;
                    rm = sa % sbv;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            8'h17: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
`endif
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [7:0] op, input logic [31:0] b);
`ifdef HILO_DIV_EN
        if ((op == 8'h16 || op == 8'h17) && b != 32'd0) return 33;
`endif
        return (b == b) ? 1 : 1;
    endfunction

    function automatic logic [63:0] div_exp(input logic [63:0] v);
`ifdef HILO_DIV_EN
        return v;
`else
        return (v & 64'd0);
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic expect_done(input logic [63:0] hilo, input int lat);
        exp_t e;
        e.hilo = hilo;
        e.cyc  = cyc + lat;
        scb.push_back(e);
    endtask

    // Drive an op for one cycle starting at a negedge; returns whether the
    // start cycle stalled.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit flush, output int stall_n);
        md_aluop_i = op;
        md_src1_i  = a;
        md_src2_i  = b;
        md_flush_i = flush;
        md_start_i = 1'b1;
        #1 stall_n = md_stall_o ? 1 : 0;
        @(negedge cpu_clk_50M);
        md_start_i = 1'b0;
        md_flush_i = 1'b0;
        #1;
    endtask

    // Wait for the scoreboard to empty (bounded), counting stall cycles
    task automatic drain(input int exp_stall, input int stall0);
        int n;
        n = stall0;
        for (int k = 0; k < 60; k++) begin
            if (scb.size() == 0) break;
            if (md_stall_o) n++;
            @(negedge cpu_clk_50M);
            #1;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", scb.size());
            scb.delete();
        end
        if (exp_stall >= 0) chk("stall_cycles", 64'(n), 64'(exp_stall));
        @(negedge cpu_clk_50M);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge cpu_clk_50M) begin
        exp_t e;
        if (md_done_o) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: pulse at cycle %0d hilo=%h, expected no pulse", cyc, md_hilo_o);
            end else begin
                e = scb.pop_front();
                chk("done_hilo", md_hilo_o, e.hilo);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;

        // Reset with a pending request: nothing may respond
        md_start_i = 1'b1;
        md_aluop_i = OP_MULT;
        md_src1_i  = 32'd5;
        md_src2_i  = 32'd7;
        repeat (3) @(negedge cpu_clk_50M);
        #1;
        chk("rst_stall", 64'(md_stall_o), 64'd0);
        chk("rst_done",  64'(md_done_o),  64'd0);
        chk("rst_hilo",  md_hilo_o,       64'd0);
        chk("rst_hilo_reg", {hi_o, lo_o}, 64'd0);
        md_start_i = 1'b0;
        rst = 1'b0;
        @(negedge cpu_clk_50M);

        // Directed ops
        expect_done(64'hFFFF_FFFF_FFFF_FFFA, 1);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, s);
        drain(1, s);

        expect_done(64'h0000_0002_FFFF_FFFA, 1);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, s);
        drain(1, s);

        lat = latency(OP_DIV, 32'd2);
        expect_done(div_exp(64'hFFFF_FFFF_FFFF_FFFD), lat);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, s);
        drain(lat, s);

        expect_done(div_exp({32'd100, 32'hFFFF_FFFF}), 1);
        issue(OP_DIVU, 32'd100, 32'd0, 1'b0, s);
        drain(1, s);

        lat = latency(OP_DIV, 32'hFFFF_FFFF);
        expect_done(div_exp(64'h0000_0000_8000_0000), lat);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, s);
        drain(lat, s);

        lat = latency(OP_DIVU, 32'd7);
        expect_done(div_exp({32'd6, 32'd142}), lat);
        issue(OP_DIVU, 32'd1000, 32'd7, 1'b0, s);
        drain(lat, s);

        // Unknown op code and flush-with-start: no stall, no done
        issue(8'h20, 32'd9, 32'd9, 1'b0, s);
        drain(0, s);
        issue(OP_MULT, 32'd9, 32'd9, 1'b1, s);
        drain(0, s);

`ifdef HILO_DIV_EN
        // Flush a divide ten cycles in, then a MULT two cycles later
        issue(OP_DIV, 32'd5000, 32'd3, 1'b0, s);
        repeat (9) @(negedge cpu_clk_50M);
        md_flush_i = 1'b1;
        @(negedge cpu_clk_50M);
        md_flush_i = 1'b0;
        #1;
        chk("flush_idle_stall", 64'(md_stall_o), 64'd0);
        @(negedge cpu_clk_50M);
        expect_done(model(OP_MULT, 32'd12, 32'hFFFF_FFFD), 1);
        issue(OP_MULT, 32'd12, 32'hFFFF_FFFD, 1'b0, s);
        drain(1, s);
`endif

        // HI/LO write while the op is in flight (RUN, or DONE without divide)
        lat = latency(OP_DIV, 32'hFFFF_FFF9);
        expect_done(model(OP_DIV, 32'd1000, 32'hFFFF_FFF9), lat);
        issue(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0, s);
        wb_whilo_i = 1'b1;
        wb_hilo_i  = 64'h1234_5678_9ABC_DEF0;
        @(negedge cpu_clk_50M);
        wb_whilo_i = 1'b0;
        #1;
        chk("hi_after_wb", 64'(hi_o), 64'h1234_5678);
        chk("lo_after_wb", 64'(lo_o), 64'h9ABC_DEF0);
        drain(-1, 0);
        chk("hilo_kept_after_done", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);

        // Reset mid-divide: everything clears and no done follows
        lat = latency(OP_DIV, 32'd3);
        if (lat == 1) expect_done(model(OP_DIV, 32'd12345, 32'd3), 1);
        issue(OP_DIV, 32'd12345, 32'd3, 1'b0, s);
        repeat (3) @(negedge cpu_clk_50M);
        #2 rst = 1'b1;
        #1;
        chk("midrst_done",  64'(md_done_o),  64'd0);
        chk("midrst_stall", 64'(md_stall_o), 64'd0);
        chk("midrst_hilo",  md_hilo_o,       64'd0);
        chk("midrst_hi",    64'(hi_o),       64'd0);
        chk("midrst_lo",    64'(lo_o),       64'd0);
        @(negedge cpu_clk_50M);
        rst = 1'b0;
        repeat (40) @(negedge cpu_clk_50M);
        chk("midrst_no_pending", 64'(scb.size()), 64'd0);

        // Randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            op  = OP_MULT + 8'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            lat = latency(op, b);
            expect_done(model(op, a, b), lat);
            issue(op, a, b, 1'b0, s);
            drain(lat, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
